flex_mode_counter: RTL and testbench
====================================

Name: flex_mode_counter

Overview:
Parametrised successor to the team's flexible counter. Counts up or down between 1 and a programmable terminal value. Supports synchronous load, continuous-wrap or one-shot operation, and a registered terminal flag. Used by timing and serial blocks that need programmable bit/sample periods, countdowns and one-shot timeouts.

Parameters:
NUM_CNT_BITS, 4, width of count, rollover_val and load_val (min 2)
WRAP_CNT_BITS, 8, width of wrap_count (optional feature only)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous clear to 0; highest priority
load_en  input  1  synchronous load of load_val; second priority
load_val  input  NUM_CNT_BITS  value loaded on load_en
count_enable  input  1  advance counter one step
dir  input  1  0 = up, 1 = down (cnt_dir_t)
mode  input  1  0 = wrap, 1 = one-shot (cnt_mode_t)
rollover_val  input  NUM_CNT_BITS  terminal/reload value
count_out  output  NUM_CNT_BITS  registered count
rollover_flag  output  1  registered: count_out equals the current terminal
done  output  1  registered, sticky one-shot completion

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: count_out=0, rollover_flag=0, done=0, state=RUN.
- Priority per cycle: clear > load_en > count_enable > hold.
- clear: next count 0, flag 0, done 0, state RUN.
- load_en: next count = load_val, done 0, state RUN. Flag is recomputed from the loaded value.
- Terminal T: up → T=rollover_val; down → T=1.
- Up step:
  - count_out >= rollover_val → next = 1 (wrap; also covers rollover_val lowered mid-count).
  - Otherwise next = count_out+1.
- Down step:
  - count_out <= 1 or count_out > rollover_val → next = rollover_val.
  - Otherwise next = count_out-1.
- rollover_val==0: counter holds 0, flag 0, done never sets; load/clear still apply.
- rollover_flag (registered) = (next == T) && rollover_val != 0. Flag is therefore high in the same cycle count_out shows T, 0 cycles of extra latency.
- dir changes take effect on the next enabled step. T is evaluated with the new dir.
- FSM, relevant only when mode=one-shot:
  - RUN: an enabled step while count_out==T stays at T (no wrap); state→DONE, done=1 next cycle.
  - DONE: count holds, count_enable ignored, flag stays 1; exit only via clear, load_en or rst.
- In wrap mode the FSM stays in RUN. Switching mode to wrap while in DONE returns to RUN next cycle with done=0.
- Arithmetic is modulo 2^NUM_CNT_BITS internally; no value outside [0, 2^N-1] is ever produced.
- rst mid-operation restores reset values immediately, independent of clk.

Optional Feature:
- FLEX_CNT_WRAP_COUNT_EN defined:
  - Adds output wrap_count [WRAP_CNT_BITS-1:0], reset 0.
  - Increments by 1 on each wrap-mode step from T (up: T→1, down: 1→rollover_val). Saturates at all-ones.
  - Cleared by clear or load_en.
- Undefined: port and register are absent.

Decomposition:
- Package flex_cnt_pkg:
  - typedef enum logic cnt_dir_t {CNT_UP, CNT_DOWN}
  - typedef enum logic cnt_mode_t {CNT_WRAP, CNT_ONESHOT}
  - typedef enum logic cnt_state_t {ST_RUN, ST_DONE}
- One sub-module, flex_cnt_step: purely combinational next-value and terminal-match logic for given count, dir, rollover_val.
- Top flex_mode_counter holds registers, priority and FSM.

Test Plan:
- N=4, up, wrap, rollover_val=5, enable held 12 cycles from reset → count 1,2,3,4,5,1,2,…; flag high exactly on cycles count=5.
- Down, wrap, rollover_val=3, from reset → 3,2,1,3,2,1; flag high when count=1.
- One-shot up, rollover_val=4 → 1,2,3,4; done=1 one cycle after the step at 4; count holds 4 with enable high; load_en load_val=2 → count 2, done 0.
- Simultaneous clear+load_en+enable at count 7 → count 0, flag 0; rollover_val changed 9→3 while count=6 (up) → next 1.
- rollover_val=0, enable 5 cycles → count stays 0, flag 0; rst asserted mid-count=3 between edges → count 0, flag 0, done 0 immediately.
- FLEX_CNT_WRAP_COUNT_EN, WRAP_CNT_BITS=2, rollover_val=2, up, wrap → wrap_count 1,2,3,3 (saturates); clear → 0.

Source files
------------

// File: rtl/flex_cnt_pkg.sv
// Shared types for flex_mode_counter: count direction, run mode and one-shot FSM state.
package flex_cnt_pkg;

    typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_t;

    typedef enum logic {CNT_WRAP, CNT_ONESHOT} cnt_mode_t;

    typedef enum logic {ST_RUN, ST_DONE} cnt_state_t;

endpackage

// File: rtl/flex_cnt_step.sv
// Combinational next-value and terminal-match logic for one counter step.
// Terminal is rollover_val when counting up and 1 when counting down.
module flex_cnt_step
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic [NUM_CNT_BITS-1:0] i_count,
    input  cnt_dir_t                i_dir,
    input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
    output logic [NUM_CNT_BITS-1:0] o_next,
    output logic [NUM_CNT_BITS-1:0] o_term,
    output logic                    o_at_term,
    output logic                    o_next_at_term
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic w_rv_nonzero;

    assign w_rv_nonzero = (i_rollover_val != '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_next = i_count;
        o_term = i_rollover_val;
        if (i_dir == CNT_UP) begin
            // >= also catches rollover_val lowered below the current count.
            if (i_count >= i_rollover_val) begin
                o_next = ONE;
            end else begin
                o_next = i_count + ONE;
            end
        end else begin
            o_term = ONE;
            if ((i_count <= ONE) || (i_count > i_rollover_val)) begin
                o_next = i_rollover_val;
            end else begin
                o_next = i_count - ONE;
            end
        end
    end

    assign o_at_term      = w_rv_nonzero && (i_count == o_term);
    assign o_next_at_term = w_rv_nonzero && (o_next == o_term);

endmodule

// File: rtl/flex_mode_counter.sv
// Up/down counter between 1 and rollover_val with load, clear, wrap or one-shot mode.
// Optional saturating wrap_count output when FLEX_CNT_WRAP_COUNT_EN is defined.
module flex_mode_counter
    import flex_cnt_pkg::*;
#(
    parameter int NUM_CNT_BITS  = 4,
    parameter int WRAP_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load_en,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  cnt_dir_t                dir,
    input  cnt_mode_t               mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    done
`ifdef FLEX_CNT_WRAP_COUNT_EN
    ,
    output logic [WRAP_CNT_BITS-1:0] wrap_count
`endif
);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    logic                    r_done;
    cnt_state_t              r_state;

    logic [NUM_CNT_BITS-1:0] w_next;
    logic [NUM_CNT_BITS-1:0] w_term;
    logic                    w_at_term;
    logic                    w_next_at_term;
    logic                    w_rv_zero;
    logic                    w_load_at_term;

    flex_cnt_step #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_step (
        .i_count        (r_count),
        .i_dir          (dir),
        .i_rollover_val (rollover_val),
        .o_next         (w_next),
        .o_term         (w_term),
        .o_at_term      (w_at_term),
        .o_next_at_term (w_next_at_term)
    );

    assign w_rv_zero      = (rollover_val == '0);
    assign w_load_at_term = !w_rv_zero && (load_val == w_term);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (clear) begin
            r_count <= '0;
            r_flag  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (load_en) begin
            r_count <= load_val;
            r_flag  <= w_load_at_term;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
        end else if (r_state == ST_DONE && mode == CNT_ONESHOT) begin
            r_count <= r_count;
        end else begin
            // Reached from DONE only after mode switched to wrap.
            r_state <= ST_RUN;
            r_done  <= 1'b0;
            r_flag  <= w_at_term;
            if (count_enable && !w_rv_zero) begin
                if (mode == CNT_ONESHOT && w_at_term) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_flag  <= 1'b1;
                end else begin
                    r_count <= w_next;
                    r_flag  <= w_next_at_term;
                end
            end
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;
    assign done          = r_done;

`ifdef FLEX_CNT_WRAP_COUNT_EN
    logic [WRAP_CNT_BITS-1:0] r_wrap_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap_count <= '0;
        end else if (clear || load_en) begin
            r_wrap_count <= '0;
        end else if (count_enable && mode == CNT_WRAP && w_at_term && r_wrap_count != '1) begin
            r_wrap_count <= r_wrap_count + 1'b1;
        end
    end

    assign wrap_count = r_wrap_count;
`endif

endmodule

// File: tb/tb_flex_mode_counter.sv
// Self-checking bench for flex_mode_counter: directed sequences plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_flex_mode_counter;
    import flex_cnt_pkg::*;

    localparam int N  = 4;
    localparam int WB = 2;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         load_en;
    logic [N-1:0] load_val;
    logic         count_enable;
    cnt_dir_t     dir;
    cnt_mode_t    mode;
    logic [N-1:0] rollover_val;
    logic [N-1:0] count_out;
    logic         rollover_flag;
    logic         done;
`ifdef FLEX_CNT_WRAP_COUNT_EN
    logic [WB-1:0] wrap_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    flex_mode_counter #(
        .NUM_CNT_BITS  (N),
        .WRAP_CNT_BITS (WB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .load_en       (load_en),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .dir           (dir),
        .mode          (mode),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .done          (done)
`ifdef FLEX_CNT_WRAP_COUNT_EN
        ,
        .wrap_count    (wrap_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer rules, done flag doubles as the one-shot "finished" state.
    int m_cnt, m_flag, m_done, m_wc;
    localparam int WC_MAX = (1 << WB) - 1;

    always @(posedge clk or posedge rst) begin
        int rv, t;
        if (rst) begin
            m_cnt = 0; m_flag = 0; m_done = 0; m_wc = 0;
        end else begin
            rv = int'(rollover_val);
            t  = (dir == CNT_DOWN) ? 1 : rv;
            if (clear) begin
                m_cnt = 0; m_done = 0; m_wc = 0;
                m_flag = 0;
            end else if (load_en) begin
                m_cnt = int'(load_val); m_done = 0; m_wc = 0;
                m_flag = (rv != 0 && m_cnt == t) ? 1 : 0;
            end else if (m_done == 1 && mode == CNT_ONESHOT) begin
                m_flag = 1;
            end else begin
                m_done = 0;
                if (count_enable && rv != 0) begin
                    if (mode == CNT_ONESHOT && m_cnt == t) begin
                        m_done = 1;
                    end else begin
                        if (mode == CNT_WRAP && m_cnt == t && m_wc < WC_MAX) m_wc++;
                        if (dir == CNT_UP) m_cnt = (m_cnt >= rv) ? 1 : m_cnt + 1;
                        else               m_cnt = (m_cnt <= 1 || m_cnt > rv) ? rv : m_cnt - 1;
                    end
                end
                m_flag = (rv != 0 && m_cnt == t) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("model_count", 32'(count_out), 32'(m_cnt));
            check("model_flag",  32'(rollover_flag), 32'(m_flag));
            check("model_done",  32'(done), 32'(m_done));
`ifdef FLEX_CNT_WRAP_COUNT_EN
            check("model_wrap_count", 32'(wrap_count), 32'(m_wc));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        clear = 0; load_en = 0; load_val = '0; count_enable = 0;
        dir = CNT_UP; mode = CNT_WRAP; rollover_val = '0;
    endtask

    initial begin
        int up_exp[12];
        int dn_exp[6];
        idle_inputs();
        rst = 1'b1;
        #12;
        check("reset_count", 32'(count_out), 0);
        check("reset_flag",  32'(rollover_flag), 0);
        check("reset_done",  32'(done), 0);
        rst = 1'b0;
        cmp_en = 1;

        // Up, wrap, rollover_val=5
        rollover_val = 4'd5; count_enable = 1;
        for (int k = 0; k < 12; k++) up_exp[k] = (k % 5) + 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("up_wrap_count", 32'(count_out), 32'(up_exp[k]));
            check("up_wrap_flag",  32'(rollover_flag), (up_exp[k] == 5) ? 1 : 0);
        end

        // Down, wrap, rollover_val=3 from reset
        do_reset();
        dir = CNT_DOWN; rollover_val = 4'd3;
        dn_exp = '{3, 2, 1, 3, 2, 1};
        for (int k = 0; k < 6; k++) begin
            tick();
            check("down_wrap_count", 32'(count_out), 32'(dn_exp[k]));
            check("down_wrap_flag",  32'(rollover_flag), (dn_exp[k] == 1) ? 1 : 0);
        end

        // One-shot up, rollover_val=4
        do_reset();
        dir = CNT_UP; mode = CNT_ONESHOT; rollover_val = 4'd4;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("oneshot_count", 32'(count_out), 32'(k));
            check("oneshot_done_low", 32'(done), 0);
        end
        tick();
        check("oneshot_done_set", 32'(done), 1);
        check("oneshot_hold_at_T", 32'(count_out), 4);
        check("oneshot_flag_held", 32'(rollover_flag), 1);
        tick(); tick();
        check("oneshot_still_held", 32'(count_out), 4);
        check("oneshot_done_sticky", 32'(done), 1);
        load_en = 1; load_val = 4'd2;
        tick();
        load_en = 0;
        check("oneshot_load_count", 32'(count_out), 2);
        check("oneshot_load_done", 32'(done), 0);
        check("oneshot_load_flag", 32'(rollover_flag), 0);

        // Clear beats load and enable; rollover_val lowered mid-count
        mode = CNT_WRAP; rollover_val = 4'd9; count_enable = 0;
        load_en = 1; load_val = 4'd7;
        tick();
        check("load7_count", 32'(count_out), 7);
        clear = 1; load_en = 1; load_val = 4'd5; count_enable = 1;
        tick();
        clear = 0; load_en = 0;
        check("priority_clear_count", 32'(count_out), 0);
        check("priority_clear_flag",  32'(rollover_flag), 0);
        count_enable = 0; load_en = 1; load_val = 4'd6;
        tick();
        load_en = 0;
        check("load6_count", 32'(count_out), 6);
        rollover_val = 4'd3; count_enable = 1;
        tick();
        check("lowered_rv_wrap", 32'(count_out), 1);

        // rollover_val=0 holds 0
        do_reset();
        rollover_val = '0; count_enable = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rv0_count", 32'(count_out), 0);
            check("rv0_flag",  32'(rollover_flag), 0);
        end

        // Async reset between edges at count 3 with done set
        mode = CNT_ONESHOT; rollover_val = 4'd3;
        tick(); tick(); tick();
        check("pre_rst_count", 32'(count_out), 3);
        tick();
        check("pre_rst_done", 32'(done), 1);
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count_out), 0);
        check("async_rst_flag",  32'(rollover_flag), 0);
        check("async_rst_done",  32'(done), 0);
        rst = 1'b0;

`ifdef FLEX_CNT_WRAP_COUNT_EN
        // Saturating wrap counter, WRAP_CNT_BITS=2
        mode = CNT_WRAP; dir = CNT_UP; rollover_val = 4'd2; count_enable = 1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 3) check("wrap_count_1", 32'(wrap_count), 1);
            if (k == 5) check("wrap_count_2", 32'(wrap_count), 2);
            if (k == 7) check("wrap_count_3", 32'(wrap_count), 3);
            if (k == 9) check("wrap_count_sat", 32'(wrap_count), 3);
        end
        clear = 1;
        tick();
        clear = 0;
        check("wrap_count_clear", 32'(wrap_count), 0);
`endif

        // Randomized traffic, model compared on every negedge
        for (int k = 0; k < 3000; k++) begin
            clear        = ($urandom_range(0, 31) == 0);
            load_en      = ($urandom_range(0, 15) == 0);
            load_val     = N'($urandom_range(0, (1 << N) - 1));
            count_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) dir  = cnt_dir_t'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mode = cnt_mode_t'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) rollover_val = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 199) == 0) do_reset();
            tick();
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
